// File: rtl/xm_mem_interface_if.sv
// Bundle of the X-Makina control-side request signals and the external
// memory bus seen by xm_mem_interface. slave = the interface block, master = its environment.
interface xm_mem_interface_if #(
  parameter int WORD = 16
);
  logic            req_i;
  logic            we_i;
  logic            byteOp_i;
  logic            byteHi_i;
  logic            badMem_i;
  logic [WORD-2:0] addr_i;
  logic [WORD-1:0] wdata_i;

  logic [WORD-1:0] rdata_o;
  logic            done_o;
  logic            err_o;
  logic            busy_o;

  logic            mem_cs_o;
  logic            mem_we_o;
  logic [1:0]      mem_be_o;
  logic [WORD-2:0] mem_addr_o;
  logic [WORD-1:0] mem_wdata_o;
  logic [WORD-1:0] mem_rdata_i;
  logic            mem_ack_i;

  modport slave (
    input  req_i, we_i, byteOp_i, byteHi_i, badMem_i, addr_i, wdata_i,
    output rdata_o, done_o, err_o, busy_o,
    output mem_cs_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i, mem_ack_i
  );

  modport master (
    output req_i, we_i, byteOp_i, byteHi_i, badMem_i, addr_i, wdata_i,
    input  rdata_o, done_o, err_o, busy_o,
    input  mem_cs_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i, mem_ack_i
  );
endinterface

// File: rtl/xm_mem_interface.sv
// Registered request/acknowledge memory bus interface for the X-Makina datapath.
// Optional bus-cycle timeout is enabled by defining XM_MEMIF_TIMEOUT_EN.
module xm_mem_interface #(
  parameter int WORD    = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk_i,
  input  logic              arst_i,
  xm_mem_interface_if.slave bus
);

  localparam int HALF = WORD / 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("xm_mem_interface: TIMEOUT must be in 1..255");
  end

  logic [1:0]      state;
  logic            byte_op_q;
  logic            byte_hi_q;
  logic [WORD-1:0] rdata_q;
  logic            done_q;
  logic            err_q;
  logic            busy_q;
  logic            cs_q;
  logic            mem_we_q;
  logic [1:0]      be_q;
  logic [WORD-2:0] addr_q;
  logic [WORD-1:0] wdata_q;

  logic [1:0]      lane_be;
  logic [WORD-1:0] lane_wdata;
  logic [WORD-1:0] rd_aligned;
  logic            timeout_hit;

  // Byte writes replicate the low byte onto both lanes; the enables pick the lane.
  always_comb begin
    lane_be    = 2'b11;
    lane_wdata = bus.wdata_i;
    if (bus.byteOp_i) begin
      lane_be    = bus.byteHi_i ? 2'b10 : 2'b01;
      lane_wdata = {bus.wdata_i[HALF-1:0], bus.wdata_i[HALF-1:0]};
    end
  end

  always_comb begin
    rd_aligned = bus.mem_rdata_i;
    if (byte_op_q) begin
      rd_aligned = byte_hi_q ? {{HALF{1'b0}}, bus.mem_rdata_i[WORD-1:HALF]}
                             : {{HALF{1'b0}}, bus.mem_rdata_i[HALF-1:0]};
    end
  end

`ifdef XM_MEMIF_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [7:0] wait_cnt;

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      wait_cnt <= 8'd0;
    end else if (state != S_BUS) begin
      wait_cnt <= 8'd0;
    end else if (!bus.mem_ack_i) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // Ack is checked first in the FSM, so a same-edge ack still completes normally.
  assign timeout_hit = (state == S_BUS) && (wait_cnt == WAIT_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state     <= S_IDLE;
      byte_op_q <= 1'b0;
      byte_hi_q <= 1'b0;
      rdata_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      cs_q      <= 1'b0;
      mem_we_q  <= 1'b0;
      be_q      <= 2'b00;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.req_i) begin
            busy_q <= 1'b1;
            if (bus.badMem_i) begin
              state   <= S_RESP;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
              rdata_q <= '0;
            end else begin
              state     <= S_BUS;
              cs_q      <= 1'b1;
              mem_we_q  <= bus.we_i;
              be_q      <= lane_be;
              addr_q    <= bus.addr_i;
              wdata_q   <= lane_wdata;
              byte_op_q <= bus.byteOp_i;
              byte_hi_q <= bus.byteHi_i;
            end
          end
        end
        S_BUS: begin
          if (bus.mem_ack_i || timeout_hit) begin
            state    <= S_RESP;
            cs_q     <= 1'b0;
            mem_we_q <= 1'b0;
            be_q     <= 2'b00;
            done_q   <= 1'b1;
            if (bus.mem_ack_i) begin
              rdata_q <= mem_we_q ? '0 : rd_aligned;
            end else begin
              err_q   <= 1'b1;
              rdata_q <= '0;
            end
          end
        end
        S_RESP: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state    <= S_IDLE;
          busy_q   <= 1'b0;
          cs_q     <= 1'b0;
          mem_we_q <= 1'b0;
          be_q     <= 2'b00;
        end
      endcase
    end
  end

  assign bus.rdata_o     = rdata_q;
  assign bus.done_o      = done_q;
  assign bus.err_o       = err_q;
  assign bus.busy_o      = busy_q;
  assign bus.mem_cs_o    = cs_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_be_o    = be_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;

endmodule
